// File: rtl/eje_02.sv
`default_nettype none
// ============================================================================
// Module   : eje_02
// Purpose  : Moore FSM controller for a start/end-of-conversion ADC
//            handshake. A go request pulses sc, waits for eoc (with a
//            timeout), asserts oe to read the result, then waits for go to
//            drop before re-arming.
// Revision : 1.0 - initial release
// ============================================================================
module eje_02 #(
   parameter int SC_CYCLES = 2,    // cycles sc is held high (>=1)
   parameter int OE_CYCLES = 1,    // cycles oe is held high (>=1)
   parameter int TIMEOUT   = 64    // max cycles in WAIT_EOC (>=2)
) (
   input  logic clk,
   input  logic reset,
   input  logic go,
   input  logic eoc,
   output logic sc,
   output logic oe,
   output logic busy,
   output logic timeout_err
);

   // One shared counter covers the longest dwell of any timed state.
   localparam int LIMIT_A = (SC_CYCLES > OE_CYCLES) ? SC_CYCLES : OE_CYCLES;
   localparam int LIMIT   = (LIMIT_A > TIMEOUT) ? LIMIT_A : TIMEOUT;
   localparam int CNT_W   = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   localparam logic [CNT_W-1:0] c_sc_last = CNT_W'(SC_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_oe_last = CNT_W'(OE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_WAIT_EOC = 3'd2,
      ST_READ     = 3'd3,
      ST_REARM    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sc_q, sc_d;
   logic             oe_q, oe_d;
   logic             busy_q, busy_d;
   logic             terr_q, terr_d;

   // Next-state logic; outputs are decoded from the next state so that the
   // registered outputs line up with the state they describe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      terr_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (go) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (cnt_q == c_sc_last) begin
               state_d = ST_WAIT_EOC;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_one;
            end
         end

         ST_WAIT_EOC: begin
            // eoc wins over the timeout when both occur on the same edge.
            if (eoc) begin
               state_d = ST_READ;
               cnt_d   = '0;
            end else if (cnt_q == c_to_last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               terr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + c_one;
            end
         end

         ST_READ: begin
            if (cnt_q == c_oe_last) begin
               state_d = ST_REARM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_one;
            end
         end

         ST_REARM: begin
            // A held go must be released before another conversion starts.
            cnt_d = '0;
            if (!go) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      sc_d   = (state_d == ST_START);
      oe_d   = (state_d == ST_READ);
      busy_d = (state_d != ST_IDLE);
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sc_q    <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sc_q    <= sc_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
      end
   end

   assign sc          = sc_q;
   assign oe          = oe_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_eje_02.sv
`default_nettype none
// ============================================================================
// Module   : tb_eje_02
// Purpose  : Self-checking bench for eje_02. A timestamp-based model predicts
//            every output each cycle; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eje_02;

   localparam int SC_CYCLES = 2;
   localparam int OE_CYCLES = 1;
   localparam int TIMEOUT   = 64;

   logic clk = 1'b0;
   logic reset, go, eoc;
   logic sc, oe, busy, timeout_err;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   eje_02 #(
      .SC_CYCLES (SC_CYCLES),
      .OE_CYCLES (OE_CYCLES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .go          (go),
      .eoc         (eoc),
      .sc          (sc),
      .oe          (oe),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Model: tracks the conversion as timestamps of when each phase ends.
   int cyc        = 0;
   bit m_busy     = 0;
   bit m_rearm    = 0;
   int sc_end     = -1;
   int wait_start = -1;
   int oe_end     = -1;
   bit exp_sc = 0, exp_oe = 0, exp_busy = 0, exp_terr = 0;

   always @(posedge clk) begin
      exp_terr = 0;
      if (reset) begin
         m_busy = 0; m_rearm = 0; sc_end = -1; wait_start = -1; oe_end = -1;
      end else if (!m_busy) begin
         if (go) begin
            m_busy = 1;
            sc_end = cyc + SC_CYCLES;
         end
      end else if (sc_end >= 0) begin
         if (cyc == sc_end) begin
            sc_end = -1;
            wait_start = cyc;
         end
      end else if (wait_start >= 0) begin
         if (eoc) begin
            wait_start = -1;
            oe_end = cyc + OE_CYCLES;
         end else if (cyc - wait_start == TIMEOUT) begin
            wait_start = -1;
            m_busy = 0;
            exp_terr = 1;
         end
      end else if (oe_end >= 0) begin
         if (cyc == oe_end) begin
            oe_end = -1;
            m_rearm = 1;
         end
      end else if (m_rearm) begin
         if (!go) begin
            m_rearm = 0;
            m_busy = 0;
         end
      end else begin
         m_busy = 0;
      end
      cyc++;
      exp_sc   = (sc_end >= 0);
      exp_oe   = (oe_end >= 0);
      exp_busy = m_busy;
   end

   // Compare process: every output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("sc", int'(sc), int'(exp_sc));
         chk("oe", int'(oe), int'(exp_oe));
         chk("busy", int'(busy), int'(exp_busy));
         chk("timeout_err", int'(timeout_err), int'(exp_terr));
      end
   end

   // Activity monitor for scenario-level literal checks.
   int sc_hi = 0, oe_hi = 0, busy_hi = 0, terr_hi = 0, sc_rise = 0, both_hi = 0;
   bit prev_sc = 0;
   always @(posedge clk) begin
      #1;
      if (sc === 1'b1) sc_hi++;
      if (oe === 1'b1) oe_hi++;
      if (busy === 1'b1) busy_hi++;
      if (timeout_err === 1'b1) terr_hi++;
      if (sc === 1'b1 && !prev_sc) sc_rise++;
      if (sc === 1'b1 && oe === 1'b1) both_hi++;
      prev_sc = (sc === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int b_sc, b_oe, b_busy, b_terr, b_rise, seen;

   initial begin
      reset = 1'b1; go = 1'b0; eoc = 1'b0;
      #1 chk_en = 1;

      // 1. Reset for two cycles, then idle.
      tick(1);
      chk("reset_sc", int'(sc), 0);
      chk("reset_busy", int'(busy), 0);
      tick(1);
      reset = 1'b0;
      tick(3);
      chk("post_reset_busy", int'(busy), 0);

      // 2. Stray eoc while idle.
      b_sc = sc_hi; b_oe = oe_hi; b_busy = busy_hi;
      tick(6);
      eoc = 1'b1; tick(2); eoc = 1'b0; tick(2);
      chk("stray_sc_cycles", sc_hi - b_sc, 0);
      chk("stray_oe_cycles", oe_hi - b_oe, 0);
      chk("stray_busy_cycles", busy_hi - b_busy, 0);

      // 3. Normal conversion.
      b_sc = sc_hi; b_oe = oe_hi; b_terr = terr_hi;
      go = 1'b1; tick(1); go = 1'b0;
      chk("norm_sc_rise", int'(sc), 1);
      tick(2);
      chk("norm_sc_fall", int'(sc), 0);
      chk("norm_wait_busy", int'(busy), 1);
      tick(4);
      eoc = 1'b1; tick(1); eoc = 1'b0;
      chk("norm_oe_latency", int'(oe), 1);
      tick(2);
      chk("norm_busy_end", int'(busy), 0);
      chk("norm_sc_cycles", sc_hi - b_sc, 2);
      chk("norm_oe_cycles", oe_hi - b_oe, 1);
      chk("norm_no_timeout", terr_hi - b_terr, 0);

      // 4. Held go: one conversion only, parked until go drops.
      b_rise = sc_rise;
      go = 1'b1; tick(4);
      eoc = 1'b1; tick(1); eoc = 1'b0;
      tick(10);
      chk("held_busy", int'(busy), 1);
      chk("held_sc_pulses", sc_rise - b_rise, 1);
      go = 1'b0; tick(2);
      chk("held_release_busy", int'(busy), 0);

      // 5. Timeout with eoc held low.
      b_oe = oe_hi; b_terr = terr_hi;
      seen = -1;
      go = 1'b1; tick(1); go = 1'b0;
      for (int i = 2; i <= 100; i++) begin
         tick(1);
         if (timeout_err === 1'b1) begin
            seen = i;
            break;
         end
      end
      chk("timeout_latency", seen, SC_CYCLES + TIMEOUT + 1);
      chk("timeout_busy_drop", int'(busy), 0);
      tick(2);
      chk("timeout_pulses", terr_hi - b_terr, 1);
      chk("timeout_no_oe", oe_hi - b_oe, 0);

      // 6. Reset while sc is high, then while oe is high.
      go = 1'b1; tick(1); go = 1'b0;
      chk("mid_sc_active", int'(sc), 1);
      reset = 1'b1; tick(1);
      chk("mid_sc_reset_sc", int'(sc), 0);
      chk("mid_sc_reset_busy", int'(busy), 0);
      reset = 1'b0; tick(2);
      go = 1'b1; tick(1); go = 1'b0; tick(3);
      eoc = 1'b1; tick(1); eoc = 1'b0;
      chk("mid_oe_active", int'(oe), 1);
      reset = 1'b1; tick(1);
      chk("mid_oe_reset_oe", int'(oe), 0);
      chk("mid_oe_reset_busy", int'(busy), 0);
      reset = 1'b0; tick(3);
      chk("mid_oe_stays_idle", int'(busy), 0);

      chk("sc_oe_exclusive", both_hi, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
